// File: rtl/gray_conv_sched_if.sv
// Bus between two Gray-coded position sources and the shared Gray-to-binary scheduler.
// The master side drives the request and code lines; the slave side returns results.
interface gray_conv_sched_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic [WIDTH-1:0] gray0;
    logic             req1;
    logic [WIDTH-1:0] gray1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] bin_out;
    logic             bin_valid;
    logic             bin_src;
    logic             step_err;
    logic [7:0]       err_cnt;

    modport master (
        output req0, gray0, req1, gray1,
        input  ack0, ack1, bin_out, bin_valid, bin_src, step_err, err_cnt
    );

    modport slave (
        input  req0, gray0, req1, gray1,
        output ack0, ack1, bin_out, bin_valid, bin_src, step_err, err_cnt
    );
endinterface

// File: rtl/gray_conv_sched.sv
// Round-robin scheduler that shares one Gray-to-binary converter between two Gray sources,
// returning the binary result with an acknowledge and flagging multi-bit Gray steps per channel.
module gray_conv_sched #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    gray_conv_sched_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] g_lat_q, g_lat_d;
    logic             sel_q, sel_d;
    logic             rr_q, rr_d;
    logic [1:0]       hist_q, hist_d;
    logic [WIDTH-1:0] last_g_q [2];
    logic [WIDTH-1:0] last_g_d [2];
    logic [WIDTH-1:0] bin_out_q, bin_out_d;
    logic             bin_src_q, bin_src_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             bin_valid_q, bin_valid_d;
    logic             step_err_q, step_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             grant_ch;
    logic             bad_step;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            g_lat_q     <= '0;
            sel_q       <= 1'b0;
            rr_q        <= 1'b0;
            hist_q      <= 2'b00;
            last_g_q[0] <= '0;
            last_g_q[1] <= '0;
            bin_out_q   <= '0;
            bin_src_q   <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            bin_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            g_lat_q     <= g_lat_d;
            sel_q       <= sel_d;
            rr_q        <= rr_d;
            hist_q      <= hist_d;
            last_g_q[0] <= last_g_d[0];
            last_g_q[1] <= last_g_d[1];
            bin_out_q   <= bin_out_d;
            bin_src_q   <= bin_src_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            bin_valid_q <= bin_valid_d;
            step_err_q  <= step_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req0 || bus.req1) state_d = CONV;
            CONV:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // On a tie the pointer names the channel that was not served last.
    assign grant_ch = (bus.req0 && bus.req1) ? rr_q : bus.req1;
    assign bad_step = hist_q[sel_q] && (popcount(g_lat_q ^ last_g_q[sel_q]) > 32'd1);

    always_comb begin
        g_lat_d     = g_lat_q;
        sel_d       = sel_q;
        rr_d        = rr_q;
        hist_d      = hist_q;
        last_g_d[0] = last_g_q[0];
        last_g_d[1] = last_g_q[1];
        bin_out_d   = bin_out_q;
        bin_src_d   = bin_src_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        bin_valid_d = 1'b0;
        step_err_d  = 1'b0;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    sel_d   = grant_ch;
                    g_lat_d = grant_ch ? bus.gray1 : bus.gray0;
                end
            end
            // Result and pulses are registered here so they are visible throughout DONE.
            CONV: begin
                bin_out_d   = gray2bin(g_lat_q);
                bin_src_d   = sel_q;
                ack0_d      = ~sel_q;
                ack1_d      = sel_q;
                bin_valid_d = 1'b1;
                step_err_d  = bad_step;
                if (bad_step && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
            end
            DONE: begin
                last_g_d[sel_q] = g_lat_q;
                hist_d[sel_q]   = 1'b1;
                rr_d            = ~sel_q;
            end
            default: ;
        endcase
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.bin_out   = bin_out_q;
    assign bus.bin_valid = bin_valid_q;
    assign bus.bin_src   = bin_src_q;
    assign bus.step_err  = step_err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_gray_conv_sched.sv
// Self-checking bench for gray_conv_sched: directed table, corner sequences and a randomized
// run against a reference model built from the Gray-code definition.
module tb_gray_conv_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    gray_conv_sched_if #(.WIDTH(4)) bus ();

    gray_conv_sched #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ch;
        logic [3:0] g;
        logic [3:0] bin;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl [10];

    // Reference model state
    logic [3:0] m_last [2];
    bit         m_hist [2];
    int         m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_bin(input logic [3:0] g);
        for (int i = 0; i < 16; i++) begin
            if (4'(i ^ (i >> 1)) == g) return 4'(i);
        end
        return 4'd0;
    endfunction

    task automatic model_reset();
        m_last[0] = 4'd0;
        m_last[1] = 4'd0;
        m_hist[0] = 0;
        m_hist[1] = 0;
        m_cnt     = 0;
    endtask

    task automatic model_conv(input logic ch, input logic [3:0] g,
                              output logic [3:0] eb, output logic ee, output logic [7:0] ec);
        ee = m_hist[ch] && ($countones(g ^ m_last[ch]) > 1);
        if (ee && m_cnt < 255) m_cnt++;
        m_last[ch] = g;
        m_hist[ch] = 1;
        eb = ref_bin(g);
        ec = 8'(m_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_conv(input logic ch, input logic [3:0] g, input logic [3:0] eb,
                           input logic ee, input logic [7:0] ec, input string tag);
        int k;
        bit seen;
        @(negedge clk);
        if (ch) begin
            bus.req1 = 1'b1;
            bus.gray1 = g;
        end else begin
            bus.req0 = 1'b1;
            bus.gray0 = g;
        end
        seen = 0;
        k = 0;
        while (!seen && k < 8) begin
            @(negedge clk);
            if (bus.bin_valid) seen = 1;
            else k++;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk({tag, "_valid_seen"}, int'(seen), 1);
        if (seen) begin
            chk({tag, "_latency"}, k, 1);
            chk({tag, "_bin_out"}, int'(bus.bin_out), int'(eb));
            chk({tag, "_bin_src"}, int'(bus.bin_src), int'(ch));
            chk({tag, "_ack_own"}, int'(ch ? bus.ack1 : bus.ack0), 1);
            chk({tag, "_ack_other"}, int'(ch ? bus.ack0 : bus.ack1), 0);
            chk({tag, "_step_err"}, int'(bus.step_err), int'(ee));
            chk({tag, "_err_cnt"}, int'(bus.err_cnt), int'(ec));
        end
    endtask

    task automatic run_conv(input logic ch, input logic [3:0] g, input string tag);
        logic [3:0] eb;
        logic ee;
        logic [7:0] ec;
        model_conv(ch, g, eb, ee, ec);
        do_conv(ch, g, eb, ee, ec, tag);
    endtask

    initial begin
        logic expch;
        int   nack;
        int   last_c;
        logic ch;
        logic [3:0] g;

        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.gray0 = 4'd0;
        bus.gray1 = 4'd0;

        tbl[0] = '{1'b0, 4'b1000, 4'b1111, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 4'b1001, 4'b1110, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 4'b0001, 4'b0001, 1'b0, 8'd0};
        tbl[3] = '{1'b0, 4'b0010, 4'b0011, 1'b1, 8'd1};
        tbl[4] = '{1'b0, 4'b0010, 4'b0011, 1'b0, 8'd1};
        tbl[5] = '{1'b1, 4'b1000, 4'b1111, 1'b0, 8'd1};
        tbl[6] = '{1'b1, 4'b1001, 4'b1110, 1'b0, 8'd1};
        tbl[7] = '{1'b0, 4'b0111, 4'b0101, 1'b1, 8'd2};
        tbl[8] = '{1'b1, 4'b0110, 4'b0100, 1'b1, 8'd3};
        tbl[9] = '{1'b0, 4'b0101, 4'b0110, 1'b0, 8'd3};

        do_reset();
        chk("rst_ack0", int'(bus.ack0), 0);
        chk("rst_ack1", int'(bus.ack1), 0);
        chk("rst_bin_valid", int'(bus.bin_valid), 0);
        chk("rst_step_err", int'(bus.step_err), 0);
        chk("rst_bin_out", int'(bus.bin_out), 0);
        chk("rst_bin_src", int'(bus.bin_src), 0);
        chk("rst_err_cnt", int'(bus.err_cnt), 0);

        for (int i = 0; i < 10; i++) begin
            do_conv(tbl[i].ch, tbl[i].g, tbl[i].bin, tbl[i].err, tbl[i].cnt,
                    $sformatf("tbl%0d", i));
        end

        // Channel 1 walks every code in Gray order: all legal single-bit steps.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_conv(1'b1, 4'(i ^ (i >> 1)), 4'(i), 1'b0, 8'd0, $sformatf("sweep%0d", i));
        end

        // Both channels requesting continuously must alternate, starting with channel 0.
        do_reset();
        @(negedge clk);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.gray0 = 4'b0101;
        bus.gray1 = 4'b1010;
        expch = 1'b0;
        nack = 0;
        last_c = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("sim_both_ack", int'(bus.ack0 && bus.ack1), 0);
            if (bus.ack0 || bus.ack1) begin
                chk("sim_order", int'(bus.ack1), int'(expch));
                chk("sim_src", int'(bus.bin_src), int'(expch));
                chk("sim_bin", int'(bus.bin_out), int'(ref_bin(expch ? 4'b1010 : 4'b0101)));
                if (nack > 0) chk("sim_gap", c - last_c, 3);
                last_c = c;
                expch = ~expch;
                nack++;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("sim_count", nack, 4);

        // Reset while in CONV drops the pending ack and clears history and counter.
        do_reset();
        run_conv(1'b0, 4'b0000, "mr_a");
        run_conv(1'b0, 4'b0011, "mr_b");
        @(negedge clk);
        bus.req0 = 1'b1;
        bus.gray0 = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("mr_ack0", int'(bus.ack0), 0);
        chk("mr_ack1", int'(bus.ack1), 0);
        chk("mr_bin_valid", int'(bus.bin_valid), 0);
        chk("mr_step_err", int'(bus.step_err), 0);
        chk("mr_bin_out", int'(bus.bin_out), 0);
        chk("mr_bin_src", int'(bus.bin_src), 0);
        chk("mr_err_cnt", int'(bus.err_cnt), 0);
        @(negedge clk);
        chk("mr_ack0_late", int'(bus.ack0), 0);
        rst = 1'b0;
        model_reset();
        do_conv(1'b0, 4'b1111, 4'b1010, 1'b0, 8'd0, "mr_after");

        // Counter saturation: 260 two-bit steps on channel 0.
        do_reset();
        run_conv(1'b0, 4'b0000, "sat_first");
        for (int i = 0; i < 260; i++) begin
            run_conv(1'b0, (i % 2 == 0) ? 4'b0011 : 4'b0000, $sformatf("sat%0d", i));
        end
        chk("sat_final", int'(bus.err_cnt), 255);

        // Randomized traffic: half single-bit steps, half arbitrary codes.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            ch = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) g = m_last[ch] ^ 4'(1 << $urandom_range(0, 3));
            else g = 4'($urandom_range(0, 15));
            run_conv(ch, g, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/gray_conv_sched.md
# gray_conv_sched

Round-robin scheduler that shares one 4-bit Gray-to-binary conversion datapath between two Gray-coded position sources, such as encoders or Gray counters. It arbitrates requests and latches the granted code. It then converts the code, returns the binary result with a one-cycle acknowledge to the winner, and flags illegal Gray steps, meaning more than one bit changed since that channel's previous sample. It sits between the Gray sources and any binary consumer, such as a position register or display driver.

## Interface
- `WIDTH`, default 4: Gray/binary word width. The design is fixed at 4; the parameter exists only for port sizing.
- `clk`, in, 1: single system clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req0`, in, 1: channel 0 conversion request (level).
- `gray0`, in, WIDTH: channel 0 Gray code. Must be held stable while `req0` is high and `ack0` has not yet pulsed.
- `req1`, in, 1: channel 1 conversion request (level).
- `gray1`, in, WIDTH: channel 1 Gray code, with the same rule as `gray0`.
- `ack0`, out, 1: one-cycle pulse marking completion for channel 0.
- `ack1`, out, 1: one-cycle pulse marking completion for channel 1.
- `bin_out`, out, WIDTH: converted binary value. Holds its value until the next conversion completes.
- `bin_valid`, out, 1: one-cycle pulse, coincident with `ack0` or `ack1`.
- `bin_src`, out, 1: channel that produced `bin_out` (0 or 1). Holds with `bin_out`.
- `step_err`, out, 1: one-cycle pulse with `bin_valid`. Signals an illegal Gray step on `bin_src`.
- `err_cnt`, out, 8: saturating count of `step_err` pulses across both channels.

## Operation
- FSM states are IDLE, CONV and DONE. Reset forces IDLE.
- **IDLE:**
  - If neither `req` is high, stay in IDLE.
  - If exactly one `req` is high, grant that channel.
  - If both are high, grant the channel not served last, per the round-robin pointer `rr`. Reset value of `rr` is 0, which means channel 0 wins the first tie.
  - On grant: latch the granted `gray` into `g_lat`, latch the channel into `sel`, and move to CONV.
- **CONV:**
  - Compute the binary value: `b[3]=g[3]`, and `b[i]=b[i+1]^g[i]` for i=2..0.
  - Register the result into `bin_out`, update `bin_src` from `sel`, and move to DONE.
- **DONE:**
  - Pulse `ack[sel]` and `bin_valid`.
  - Evaluate the step check against `last_g[sel]`:
    - If `hist[sel]` is set and `popcount(g_lat ^ last_g[sel])` is greater than 1, pulse `step_err`.
    - If `err_cnt` is below 255, increment it. At 255 it saturates.
    - Distance 0 (repeated sample) is legal.
  - Update `last_g[sel]` to `g_lat`, set `hist[sel]`, set `rr` to the channel not in `sel`, and return to IDLE.
- **Handshake:**
  - `req` is sampled only in IDLE.
  - A requester that still holds `req` high in the cycle after its `ack` issues a new request; back-to-back conversions are legal.
  - Inputs are ignored while in CONV or DONE.
- **No history yet:** the first conversion on a channel after reset never raises `step_err`.
- **Values at reset:**
  - Outputs: `ack0=ack1=bin_valid=step_err=0`, `bin_out=0`, `bin_src=0`, `err_cnt=0`.
  - Internal state: `hist=2'b00`, `last_g` both 0, `rr=0`.

## Timing
- All outputs are registered.
- Latency: `req` sampled high in IDLE at edge E0; CONV occupies E0→E1; DONE occupies E1→E2. `ack`, `bin_valid` and `step_err` are high for the single cycle after E1 and low after E2.
- `bin_out` and `bin_src` are valid from E1 onward and hold until the next CONV edge.
- Throughput is one conversion per 3 cycles. With both channels continuously requesting, the channels alternate strictly.
- Reset asserted mid-operation: at the next edge the FSM returns to IDLE, any pending `ack` is dropped, and history, pointer and counter are all cleared.

## Test plan
- **Single request:** reset, then `req0=1`, `gray0=4'b1000`. Expect `ack0` and `bin_valid` 2 cycles later with `bin_out=4'b1111`, `bin_src=0`, `step_err=0`, and `ack1` never high.
- **Exhaustive code sweep:** channel 1 steps through all 16 Gray codes in Gray order (0000, 0001, 0011, 0010 … 1000). Expect `bin_out` 0..15 in sequence, `bin_src=1`, and `step_err` never pulsing.
- **Simultaneous requests:** `req0=req1=1` held for 12 cycles after reset. Expect grants in the order 0,1,0,1, with exactly one `ack` per 3 cycles and no cycle having both `ack` high.
- **Illegal step:** channel 0 converts 4'b0001, then 4'b0010 (2 bits changed). Expect the second conversion to give `bin_out=4'b0011` with `step_err=1` and `err_cnt=1`. A following 4'b0010 gives `step_err=0`.
- **Reset mid-conversion:** assert `rst` in CONV. Expect no `ack`, all outputs at reset values, and the next conversion on that channel to have no `step_err` even for a non-adjacent code.
- **Counter saturation:** force 260 illegal steps. Expect `err_cnt` to stop at 255 while `step_err` keeps pulsing.
